// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit: shift-add multiply and restoring divide, one bit per cycle.
// Optional MDU_EARLY_OUT_EN: trivial multiplies, divide-by-zero and signed overflow finish in one cycle.
module mdu_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       funct,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             zero,
  output logic             err
);
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_e;

  localparam int              CW      = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]   LAST    = CW'(WIDTH);
  localparam logic [3:0]      F_MUL   = 4'd0;
  localparam logic [3:0]      F_MULH  = 4'd1;
  localparam logic [3:0]      F_MULHU = 4'd2;
  localparam logic [3:0]      F_DIV   = 4'd3;
  localparam logic [3:0]      F_DIVU  = 4'd4;
  localparam logic [3:0]      F_REM   = 4'd5;
  localparam logic [3:0]      F_REMU  = 4'd6;

  function automatic logic [WIDTH-1:0] cneg(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? (~v + WIDTH'(1)) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] cneg2(input logic [2*WIDTH-1:0] v, input logic neg);
    return neg ? (~v + (2*WIDTH)'(1)) : v;
  endfunction

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               fast_q, fast_d;
  logic [3:0]         fn_q, fn_d;
  logic               sa_q, sa_d, sb_q, sb_d;
  logic [WIDTH:0]     hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d, dv_q, dv_d;
  logic [WIDTH-1:0]   s_q, s_d;
  logic               zero_q, zero_d, err_q, err_d;

  logic               accept, legal, is_div_in, is_sgn_in, a_neg_in, b_neg_in, fast_in, early;
  logic [WIDTH-1:0]   a_mag, b_mag, early_s;
  logic signed [WIDTH-1:0] a_sgn, b_sgn;
  logic [WIDTH:0]     mul_sum, div_shift;
  logic [WIDTH+1:0]   div_diff;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   res;

  assign accept    = in_valid && in_ready;
  assign legal     = (funct <= F_REMU);
  assign is_div_in = legal && (funct >= F_DIV);
  assign is_sgn_in = (funct == F_MULH) || (funct == F_DIV) || (funct == F_REM);
  assign a_sgn     = $signed(a);
  assign b_sgn     = $signed(b);
  assign a_neg_in  = is_sgn_in && (a_sgn < 0);
  assign b_neg_in  = is_sgn_in && (b_sgn < 0);
  // The most-negative value maps onto itself, which read unsigned is its true magnitude.
  assign a_mag     = cneg(a, a_neg_in);
  assign b_mag     = cneg(b, b_neg_in);

`ifdef MDU_EARLY_OUT_EN
  function automatic logic [WIDTH-1:0] early_res(input logic [3:0] f, input logic [WIDTH-1:0] av,
                                                 input logic [WIDTH-1:0] bv);
    if (f <= F_MULHU) return '0;
    if (bv == '0)     return ((f == F_DIV) || (f == F_DIVU)) ? '1 : av;
    return (f == F_DIV) ? av : '0;
  endfunction

  assign early   = legal && ((!is_div_in && ((a == '0) || (b == '0))) || (is_div_in && (b == '0)) ||
                   (((funct == F_DIV) || (funct == F_REM)) && (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1)));
  assign early_s = early_res(funct, a, b);
`else
  assign early   = 1'b0;
  assign early_s = '0;
`endif

  assign fast_in = !legal || early;

  assign mul_sum   = hi_q + {1'b0, (lo_q[0] ? dv_q : {WIDTH{1'b0}})};
  assign div_shift = {hi_q[WIDTH-1:0], lo_q[WIDTH-1]};
  assign div_diff  = {1'b0, div_shift} - {2'b00, dv_q};
  assign prod      = cneg2({hi_q[WIDTH-1:0], lo_q}, (fn_q == F_MULH) && (sa_q ^ sb_q));

  always_comb begin
    res = '0;
    case (fn_q)
      F_MUL:           res = prod[WIDTH-1:0];
      F_MULH, F_MULHU: res = prod[2*WIDTH-1:WIDTH];
      F_DIV:           res = (dv_q == '0) ? '1 : cneg(lo_q, sa_q ^ sb_q);
      F_DIVU:          res = lo_q;
      F_REM:           res = cneg(hi_q[WIDTH-1:0], sa_q);
      F_REMU:          res = hi_q[WIDTH-1:0];
      default:         res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      fast_q  <= 1'b0;
      s_q     <= '0;
      zero_q  <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fast_q  <= fast_d;
      s_q     <= s_d;
      zero_q  <= zero_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    fn_q <= fn_d;
    sa_q <= sa_d;
    sb_q <= sb_d;
    hi_q <= hi_d;
    lo_q <= lo_d;
    dv_q <= dv_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = BUSY;
      BUSY:    if (fast_q || (cnt_q == LAST)) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d  = cnt_q;
    fast_d = fast_q;
    fn_d   = fn_q;
    sa_d   = sa_q;
    sb_d   = sb_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    dv_d   = dv_q;
    s_d    = s_q;
    zero_d = zero_q;
    err_d  = err_q;
    if ((state_q == IDLE) && accept) begin
      cnt_d  = '0;
      fast_d = fast_in;
      fn_d   = funct;
      sa_d   = a_neg_in;
      sb_d   = b_neg_in;
      hi_d   = '0;
      lo_d   = is_div_in ? a_mag : b_mag;
      dv_d   = is_div_in ? b_mag : a_mag;
      // Short-circuit results are posted now; BUSY then lasts a single cycle.
      if (fast_in) begin
        s_d    = legal ? early_s : '0;
        zero_d = legal ? (early_s == '0) : 1'b1;
        err_d  = !legal;
      end
    end else if ((state_q == BUSY) && !fast_q) begin
      if (cnt_q != LAST) begin
        cnt_d = cnt_q + CW'(1);
        if (fn_q >= F_DIV) begin
          hi_d = div_diff[WIDTH+1] ? div_shift : div_diff[WIDTH:0];
          lo_d = {lo_q[WIDTH-2:0], !div_diff[WIDTH+1]};
        end else begin
          hi_d = {1'b0, mul_sum[WIDTH:1]};
          lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
        end
      end else begin
        s_d    = res;
        zero_d = (res == '0);
        err_d  = 1'b0;
      end
    end
  end

  always_comb begin
    in_ready  = (state_q == IDLE) && !rst;
    out_valid = (state_q == DONE);
    s         = s_q;
    zero      = zero_q;
    err       = err_q;
  end
endmodule

// File: tb/tb_mdu_iter.sv
// Bench for mdu_iter: vector table through a scoreboard queue, plus backpressure and reset sequences.
module tb_mdu_iter;
  localparam int W   = 32;
  localparam int LAT = W + 1;
`ifdef MDU_EARLY_OUT_EN
  localparam bit EO = 1'b1;
`else
  localparam bit EO = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, out_valid, out_ready, zero, err;
  logic [W-1:0] a, b, s;
  logic [3:0]   funct;

  always #5 clk = ~clk;

  mdu_iter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .funct(funct), .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .zero(zero), .err(err)
  );

  typedef struct {
    logic [3:0]   f;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] es;
    logic         ez;
    logic         ee;
    bit           fast;
    int           hold;
  } vec_t;

  typedef struct {
    logic [W-1:0] s;
    logic         z;
    logic         e;
    int           lat;
  } exp_t;

  exp_t sbq[$];
  vec_t vt[$];
  int   n_run  = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_run++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  task automatic run_op(input vec_t v, input string nm);
    exp_t e, got;
    int   n;
    e.s   = v.es;
    e.z   = v.ez;
    e.e   = v.ee;
    e.lat = ((v.f > 4'd6) || (v.fast && EO)) ? 1 : LAT;
    n = 0;
    while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
    chk({nm, " in_ready"}, 64'(in_ready), 64'(1));
    funct = v.f; a = v.a; b = v.b; in_valid = 1'b1;
    sbq.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0; a = $urandom; b = $urandom; funct = 4'($urandom);
    n = 0;
    while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
    got = sbq.pop_front();
    chk({nm, " latency"}, 64'(n), 64'(got.lat));
    chk({nm, " s"}, 64'(s), 64'(got.s));
    chk({nm, " zero"}, 64'(zero), 64'(got.z));
    chk({nm, " err"}, 64'(err), 64'(got.e));
    chk({nm, " busy in_ready"}, 64'(in_ready), 64'(0));
    if (v.hold > 0) in_valid = 1'b1;
    for (int i = 0; i < v.hold; i++) begin
      @(posedge clk); #1;
      chk({nm, " hold s"}, 64'(s), 64'(got.s));
      chk({nm, " hold zero/err"}, 64'({zero, err}), 64'({got.z, got.e}));
      chk({nm, " hold valid/ready"}, 64'({out_valid, in_ready}), 64'(2'b10));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b0;
    chk({nm, " post valid/ready"}, 64'({out_valid, in_ready}), 64'(2'b01));
  endtask

  initial begin
    int n;
    vt.push_back('{4'd0, 32'h00010003, 32'h00010005, 32'h0008000F, 1'b0, 1'b0, 1'b0, 0});
    vt.push_back('{4'd2, 32'h00010003, 32'h00010005, 32'h00000001, 1'b0, 1'b0, 1'b0, 0});
    vt.push_back('{4'd1, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 0});
    vt.push_back('{4'd2, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 1'b0, 1'b0, 1'b0, 0});
    vt.push_back('{4'd3, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 1'b0, 1'b0, 1'b0, 0});
    vt.push_back('{4'd5, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 0});
    vt.push_back('{4'd4, 32'd100,      32'd7,        32'h0000000E, 1'b0, 1'b0, 1'b0, 10});
    vt.push_back('{4'd6, 32'd100,      32'd7,        32'h00000002, 1'b0, 1'b0, 1'b0, 0});
    vt.push_back('{4'd4, 32'h00001234, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1, 0});
    vt.push_back('{4'd6, 32'h00001234, 32'h00000000, 32'h00001234, 1'b0, 1'b0, 1'b1, 0});
    vt.push_back('{4'd3, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1'b0, 1'b1, 0});
    vt.push_back('{4'd5, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 1'b1, 0});
    vt.push_back('{4'd8, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b1, 1'b1, 1'b1, 0});
    vt.push_back('{4'd0, 32'h00000000, 32'h00001234, 32'h00000000, 1'b1, 1'b0, 1'b1, 0});
    vt.push_back('{4'd1, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0, 1'b0, 1'b0, 0});
    vt.push_back('{4'd3, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0, 1'b0, 1'b0, 0});
    vt.push_back('{4'd5, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 1'b0, 1'b0, 1'b0, 0});
    vt.push_back('{4'd5, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 1'b0, 1'b0, 1'b1, 0});
    vt.push_back('{4'd3, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1, 0});
    vt.push_back('{4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 0});
    vt.push_back('{4'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0, 0});
    vt.push_back('{4'd3, 32'h80000000, 32'h00000001, 32'h80000000, 1'b0, 1'b0, 1'b0, 0});
    vt.push_back('{4'd7, 32'h00000005, 32'h00000003, 32'h00000000, 1'b1, 1'b1, 1'b1, 0});
    vt.push_back('{4'd15, 32'h00000005, 32'h00000003, 32'h00000000, 1'b1, 1'b1, 1'b1, 3});

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; funct = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset out_valid", 64'(out_valid), 64'(0));
    chk("reset s", 64'(s), 64'(0));
    chk("reset zero/err", 64'({zero, err}), 64'(2'b10));
    rst = 1'b0;
    #1;
    chk("reset in_ready", 64'(in_ready), 64'(1));

    for (int i = 0; i < vt.size(); i++) run_op(vt[i], $sformatf("vec%0d", i));

    // Reset in the middle of a multiply: the operation must vanish.
    funct = 4'd0; a = 32'h00001234; b = 32'h00005678; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    chk("midrst busy", 64'({out_valid, in_ready}), 64'(2'b00));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("midrst in_ready", 64'(in_ready), 64'(1));
    chk("midrst out_valid", 64'(out_valid), 64'(0));
    chk("midrst s/zero", 64'({s, zero}), 64'({32'h0, 1'b1}));
    n = 0;
    repeat (40) begin @(posedge clk); #1; if (out_valid) n++; end
    chk("midrst no response", 64'(n), 64'(0));
    run_op('{4'd0, 32'd3, 32'd5, 32'h0000000F, 1'b0, 1'b0, 1'b0, 0}, "mul3x5");

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
